gppcu_instr_dispatch: RTL and testbench

GPPCU_INSTR_DISPATCH -- requirements
Module: gppcu_instr_dispatch

---
 rtl/gppcu_instr_dispatch.sv | 120 ++++++++++++
 tb/tb_gppcu_instr_dispatch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_instr_dispatch.sv
// Host-fed instruction FIFO and dispatcher for the GPPCU core.
// The host fills the FIFO, START drains it through a valid/ready register into the core.
module gppcu_instr_dispatch #(
   parameter int FIFO_AW = 4
) (
   input  logic               iACLK,
   input  logic               iARESETn,
   input  logic [31:0]        iHOST_WDATA,
   input  logic               iHOST_WR,
   output logic               oHOST_FULL,
   output logic [FIFO_AW:0]   oFIFO_LEVEL,
   input  logic               iHOST_START,
   input  logic               iHOST_ABORT,
   output logic               oBUSY,
   output logic               oDONE,
   output logic               oOVERFLOW,
   output logic [15:0]        oISSUE_COUNT,
   output logic [31:0]        oINSTR,
   output logic               oINSTR_VALID,
   input  logic               iINSTR_READY,
   output logic [1:0]         dbg_state
);

   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [31:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wptr, rptr;
   logic [FIFO_AW:0]   level;
   logic [31:0]        instr;
   logic               instr_valid;
   logic [15:0]        issue_cnt;
   logic               overflow;

   logic full, empty, push, pop, hs, start_ok, run_end;

   // Handshake: oINSTR_VALID is raised by the dispatcher and held with oINSTR
   // unchanged until a cycle where iINSTR_READY is also high; that cycle is the
   // transfer. Only abort or reset can withdraw a presented instruction.
   assign full     = (level == (FIFO_AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign push     = iARESETn && iHOST_WR && !full && !iHOST_ABORT;
   assign hs       = instr_valid && iINSTR_READY;
   assign pop      = (state == S_RUN) && !empty && (!instr_valid || iINSTR_READY) && !iHOST_ABORT;
   assign start_ok = (state == S_IDLE) && iHOST_START && !iHOST_ABORT;
   assign run_end  = (state == S_RUN) && empty && (!instr_valid || iINSTR_READY);

   always_ff @(posedge iACLK) begin
      if (!iARESETn) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_RUN;
         S_RUN:   if (run_end)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (iHOST_ABORT) state_nxt = S_IDLE;
   end

   // Storage carries no reset; the pointers and level define what is valid.
   always_ff @(posedge iACLK) begin
      if (push) mem[wptr] <= iHOST_WDATA;
   end

   always_ff @(posedge iACLK) begin
      if (!iARESETn) begin
         wptr        <= '0;
         rptr        <= '0;
         level       <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         issue_cnt   <= '0;
         overflow    <= 1'b0;
      end else if (iHOST_ABORT) begin
         wptr        <= '0;
         rptr        <= '0;
         level       <= '0;
         instr_valid <= 1'b0;
      end else begin
         if (push) wptr <= wptr + FIFO_AW'(1);
         if (pop) begin
            rptr        <= rptr + FIFO_AW'(1);
            instr       <= mem[rptr];
            instr_valid <= 1'b1;
         end else if (hs) begin
            instr_valid <= 1'b0;
         end
         level <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

         if (start_ok)                         issue_cnt <= '0;
         else if (hs && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;

         // A drop in the same cycle as START still leaves the flag set.
         if (iHOST_WR && full) overflow <= 1'b1;
         else if (start_ok)    overflow <= 1'b0;
      end
   end

   assign oHOST_FULL   = full;
   assign oFIFO_LEVEL  = level;
   assign oBUSY        = (state == S_RUN);
   assign oDONE        = (state == S_DONE);
   assign oOVERFLOW    = overflow;
   assign oISSUE_COUNT = issue_cnt;
   assign oINSTR       = instr;
   assign oINSTR_VALID = instr_valid;
   assign dbg_state    = state;

endmodule

// File: tb/tb_gppcu_instr_dispatch.sv
// Randomised bench for gppcu_instr_dispatch: a queue model of the program
// feeds an expected queue that a negedge monitor drains on every transfer.
module tb_gppcu_instr_dispatch;

   localparam int FIFO_AW = 4;
   localparam int DEPTH   = 1 << FIFO_AW;

   logic               clk = 1'b0;
   logic               rstn;
   logic [31:0]        host_wdata;
   logic               host_wr;
   logic               host_full;
   logic [FIFO_AW:0]   fifo_level;
   logic               host_start;
   logic               host_abort;
   logic               busy;
   logic               done;
   logic               overflow;
   logic [15:0]        issue_count;
   logic [31:0]        instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [1:0]         dbg_state;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];
   int mdl_lvl = 0;
   logic mdl_ovf = 1'b0;
   int done_cnt = 0;
   int valid_cnt = 0;
   logic stall_pend = 1'b0;
   logic [31:0] stall_word = '0;

   gppcu_instr_dispatch #(.FIFO_AW(FIFO_AW)) dut (
      .iACLK        (clk),
      .iARESETn     (rstn),
      .iHOST_WDATA  (host_wdata),
      .iHOST_WR     (host_wr),
      .oHOST_FULL   (host_full),
      .oFIFO_LEVEL  (fifo_level),
      .iHOST_START  (host_start),
      .iHOST_ABORT  (host_abort),
      .oBUSY        (busy),
      .oDONE        (done),
      .oOVERFLOW    (overflow),
      .oISSUE_COUNT (issue_count),
      .oINSTR       (instr),
      .oINSTR_VALID (instr_valid),
      .iINSTR_READY (instr_ready),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: transfers, stall stability, done pulses.
   always @(negedge clk) begin
      if (!rstn) begin
         stall_pend = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            check("done_busy_low", busy, 1'b0);
         end
         if (instr_valid) valid_cnt++;
         if (stall_pend) begin
            check("stall_valid_held", instr_valid, 1'b1);
            check("stall_instr_stable", instr, stall_word);
         end
         stall_pend = 1'b0;
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL issue_unexpected: got 0x%08h, expected no transfer", instr);
            end else begin
               check("issue_word", instr, exp_q.pop_front());
            end
         end else if (instr_valid && !host_abort) begin
            stall_pend = 1'b1;
            stall_word = instr;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_level", fifo_level, 0);
      check("rst_full", host_full, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_count", issue_count, 0);
   endtask

   task automatic push_word(input logic [31:0] w);
      host_wr    = 1'b1;
      host_wdata = w;
      if (mdl_lvl < DEPTH) begin
         exp_q.push_back(w);
         mdl_lvl++;
      end else begin
         mdl_ovf = 1'b1;
      end
      tick();
      host_wr = 1'b0;
      check("push_level", fifo_level, mdl_lvl);
      check("push_full", host_full, (mdl_lvl == DEPTH));
      check("push_overflow", overflow, mdl_ovf);
   endtask

   // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready
   task automatic run_program(input int mode);
      int n;
      int start_done;
      int start_valid;
      int k;
      n           = exp_q.size();
      start_done  = done_cnt;
      start_valid = valid_cnt;
      k           = 0;
      host_start  = 1'b1;
      tick();
      host_start  = 1'b0;
      mdl_ovf     = 1'b0;
      check("start_busy", busy, 1'b1);
      check("start_ovf_clear", overflow, 1'b0);
      check("start_count_clear", issue_count, 0);
      check("start_valid_low", instr_valid, 1'b0);
      while (done_cnt == start_done && k < 300) begin
         case (mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = ((k % 3) == 0);
            default: instr_ready = 1'($urandom_range(0, 1));
         endcase
         tick();
         k++;
         if (k == 1) check("first_valid_latency", instr_valid, (n > 0));
      end
      if (done_cnt == start_done) begin
         tests++;
         fails++;
         $display("FAIL run_timeout: got no done pulse after %0d cycles, expected one", k);
      end
      if (mode == 0) check("run_cycles", k, n + 2);
      instr_ready = 1'b0;
      tick();
      tick();
      check("done_pulses", done_cnt - start_done, 1);
      check("issue_count", issue_count, n);
      check("exp_drained", exp_q.size(), 0);
      check("end_busy", busy, 1'b0);
      check("end_valid", instr_valid, 1'b0);
      check("end_level", fifo_level, 0);
      if (n == 0) check("empty_valid_never", valid_cnt - start_valid, 0);
      mdl_lvl = 0;
   endtask

   initial begin
      int n_words;
      int start_done;
      rstn        = 1'b0;
      host_wdata  = '0;
      host_wr     = 1'b0;
      host_start  = 1'b0;
      host_abort  = 1'b0;
      instr_ready = 1'b0;
      tick();
      tick();
      check_reset_outputs();
      rstn = 1'b1;
      tick();

      // basic program, ready always high
      push_word(32'h11);
      push_word(32'h22);
      push_word(32'h33);
      run_program(0);

      // same program, stalling ready
      push_word(32'h11);
      push_word(32'h22);
      push_word(32'h33);
      run_program(1);

      // empty program
      run_program(0);

      // overflow: 17 pushes, 17th dropped; drain wraps the pointers
      for (int i = 0; i < 17; i++) push_word($urandom);
      run_program(2);

      // abort while presenting with 5 words queued
      for (int i = 0; i < 6; i++) push_word($urandom);
      host_start = 1'b1;
      tick();
      host_start  = 1'b0;
      mdl_ovf     = 1'b0;
      instr_ready = 1'b0;
      tick();
      check("abort_pre_valid", instr_valid, 1'b1);
      check("abort_pre_level", fifo_level, 5);
      start_done = done_cnt;
      host_abort = 1'b1;
      host_wr    = 1'b1;
      host_wdata = 32'hDEAD_BEEF;
      tick();
      host_abort = 1'b0;
      host_wr    = 1'b0;
      exp_q.delete();
      mdl_lvl = 0;
      check("abort_valid", instr_valid, 1'b0);
      check("abort_level", fifo_level, 0);
      check("abort_busy", busy, 1'b0);
      tick();
      tick();
      check("abort_no_done", done_cnt - start_done, 0);
      check("abort_level_hold", fifo_level, 0);

      // reset for one edge in the middle of a run
      for (int i = 0; i < 6; i++) push_word($urandom);
      host_start = 1'b1;
      tick();
      host_start  = 1'b0;
      instr_ready = 1'b1;
      tick();
      tick();
      tick();
      rstn        = 1'b0;
      instr_ready = 1'b0;
      tick();
      check_reset_outputs();
      exp_q.delete();
      mdl_lvl = 0;
      mdl_ovf = 1'b0;
      rstn    = 1'b1;
      tick();
      push_word(32'h11);
      push_word(32'h22);
      push_word(32'h33);
      run_program(0);

      // random programs
      for (int p = 0; p < 8; p++) begin
         n_words = $urandom_range(0, 20);
         for (int i = 0; i < n_words; i++) push_word($urandom);
         run_program($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
